// File: rtl/lcd_bus_responder.sv
// ============================================================================
//  Module      : lcd_bus_responder
//  Description : HD44780-style character display responder. Decodes the
//                E/RS/RW/DB bus into a 2x16 DDRAM, answers busy-flag and
//                data reads, and exposes the display contents on a side port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_bus_responder #(
  parameter int BUSY_CYCLES = 40,
  parameter int CLR_CYCLES  = 1640
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       E,
  input  logic       RW,
  input  logic       RS,
  input  logic [7:0] DB_in,
  output logic [7:0] DB_out,
  output logic       DB_oe,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [4:0] cursor,
  output logic       busy,
  output logic       display_on,
  output logic       cmd_err
);

  // Busy down-counter is sized for the longer of the two busy periods.
  localparam int MAX_CYCLES = (BUSY_CYCLES > CLR_CYCLES) ? BUSY_CYCLES : CLR_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] BUSY_LOAD     = CNT_W'(BUSY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLR_LOAD      = CNT_W'(CLR_CYCLES - 1);
  // The sweep itself occupies 32 busy cycles; the tail covers the rest.
  localparam logic [CNT_W-1:0] CLR_TAIL_LOAD = CNT_W'((CLR_CYCLES > 32) ? (CLR_CYCLES - 33) : 0);
  localparam logic [7:0]       BLANK         = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY     = 2'd1,
    ST_CLEARING = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] busy_cnt;
  logic [4:0]       clr_idx;
  logic             incr_mode;

  logic [7:0]       ddram [32];

  // Two-flop synchronizer stages plus the previous synchronized E for edge detect
  logic       e_meta, e_sync, e_prev;
  logic       rw_meta, rw_sync;
  logic       rs_meta, rs_sync;
  logic [7:0] db_meta, db_sync;

  // Bus fields held from the last cycle the synchronized E was high
  logic       rw_cap, rs_cap;
  logic [7:0] db_cap;

  logic       e_fall;
  logic       busy_eff;
  logic       data_wr;
  logic [4:0] cursor_step;

  // Bring the asynchronous bus into the clk domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_meta  <= 1'b0;
      e_sync  <= 1'b0;
      e_prev  <= 1'b0;
      rw_meta <= 1'b0;
      rw_sync <= 1'b0;
      rs_meta <= 1'b0;
      rs_sync <= 1'b0;
      db_meta <= 8'h00;
      db_sync <= 8'h00;
    end else begin
      e_meta  <= E;
      e_sync  <= e_meta;
      e_prev  <= e_sync;
      rw_meta <= RW;
      rw_sync <= rw_meta;
      rs_meta <= RS;
      rs_sync <= rs_meta;
      db_meta <= DB_in;
      db_sync <= db_meta;
    end
  end

  // Hold the bus fields seen while E was high so a late DB change after E fall is harmless
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rw_cap <= 1'b0;
      rs_cap <= 1'b0;
      db_cap <= 8'h00;
    end else if (e_sync) begin
      rw_cap <= rw_sync;
      rs_cap <= rs_sync;
      db_cap <= db_sync;
    end
  end

  // Edge detect, effective busy and the address-counter step
  always_comb begin
    e_fall = e_prev & ~e_sync;
    // The final counted BUSY cycle already counts as free, so a bus cycle
    // completing exactly as busy drops is accepted.
    busy_eff    = (state == ST_CLEARING) | ((state == ST_BUSY) & (busy_cnt != '0));
    data_wr     = e_fall & ~rw_cap & rs_cap & ~busy_eff;
    cursor_step = incr_mode ? (cursor + 5'd1) : (cursor - 5'd1);
  end

  // Display RAM: blanked asynchronously on reset, swept during clear, written by data writes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        ddram[i] <= BLANK;
      end
    end else if (state == ST_CLEARING) begin
      ddram[clr_idx] <= BLANK;
    end else if (data_wr) begin
      ddram[cursor] <= db_cap;
    end
  end

  // Control FSM: busy timing, clear sweep, instruction decode and error pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      busy_cnt   <= '0;
      clr_idx    <= 5'd0;
      cursor     <= 5'd0;
      incr_mode  <= 1'b1;
      display_on <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      cmd_err <= 1'b0;

      case (state)
        ST_CLEARING: begin
          clr_idx <= clr_idx + 5'd1;
          if (clr_idx == 5'd31) begin
            if (CLR_CYCLES > 32) begin
              state    <= ST_BUSY;
              busy_cnt <= CLR_TAIL_LOAD;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_BUSY: begin
          if (busy_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            busy_cnt <= busy_cnt - 1'b1;
          end
        end
        default: ;
      endcase

      // Bus cycle decode; assignments here override the timing updates above
      if (e_fall) begin
        if (rw_cap) begin
          // Status reads have no side effect; data reads advance the cursor
          if (rs_cap) begin
            if (busy_eff) begin
              cmd_err <= 1'b1;
            end else begin
              cursor <= cursor_step;
            end
          end
        end else if (busy_eff) begin
          cmd_err <= 1'b1;
        end else if (rs_cap) begin
          cursor   <= cursor_step;
          state    <= ST_BUSY;
          busy_cnt <= BUSY_LOAD;
        end else begin
          casez (db_cap)
            8'b1???????: begin
              // Only 0x00-0x0F and 0x40-0x4F are real DDRAM addresses
              if (db_cap[5:4] == 2'b00) begin
                cursor   <= {db_cap[6], db_cap[3:0]};
                state    <= ST_BUSY;
                busy_cnt <= BUSY_LOAD;
              end else begin
                cmd_err <= 1'b1;
              end
            end
            8'b01??????: begin
              // CGRAM is not modelled
              cmd_err <= 1'b1;
            end
            8'b001?????: begin
              state    <= ST_BUSY;
              busy_cnt <= BUSY_LOAD;
            end
            8'b0001????: begin
              // Display shift (bit 3) is accepted but has no visible effect
              if (!db_cap[3]) begin
                cursor <= db_cap[2] ? (cursor + 5'd1) : (cursor - 5'd1);
              end
              state    <= ST_BUSY;
              busy_cnt <= BUSY_LOAD;
            end
            8'b00001???: begin
              display_on <= db_cap[2];
              state      <= ST_BUSY;
              busy_cnt   <= BUSY_LOAD;
            end
            8'b000001??: begin
              incr_mode <= db_cap[1];
              state     <= ST_BUSY;
              busy_cnt  <= BUSY_LOAD;
            end
            8'b0000001?: begin
              cursor   <= 5'd0;
              state    <= ST_BUSY;
              busy_cnt <= CLR_LOAD;
            end
            8'b00000001: begin
              cursor    <= 5'd0;
              incr_mode <= 1'b1;
              clr_idx   <= 5'd0;
              state     <= ST_CLEARING;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Read bus, side port and status outputs
  always_comb begin
    busy    = (state != ST_IDLE);
    rd_data = ddram[rd_addr];
    DB_oe   = e_sync & rw_sync;
    DB_out  = 8'h00;
    if (DB_oe) begin
      if (rs_sync) begin
        DB_out = busy_eff ? 8'h00 : ddram[cursor];
      end else begin
        DB_out = {busy, cursor[4], 2'b00, cursor[3:0]};
      end
    end
  end

endmodule

`default_nettype wire
